rf8088_bus_arb: RTL and testbench
=================================

# rf8088_bus_arb

Two-master arbiter/sequencer that shares the single 128-bit fta bus between the instruction-bundle fill path (master 0) and the rf8088 core's data master (master 1). Both masters issue one-cycle request pulses. The arbiter latches each pulse, grants the bus round-robin, and issues exactly one transaction at a time to the slave side. It handles retry and timeout, and routes the single-cycle response back to the owning master. It sits between the core and icache fill logic on one side and the system fta bus on the other.

## Interface
- TIMEOUT, 1024: cycles in WAIT with no ack/rty before an error response is synthesized.
- RETRY_DLY, 4: cycles spent in BACKOFF before reissuing a request that got rty.
- MAX_RETRY, 7: reissues allowed per request; the next rty after that is forwarded to the master.

- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- m0_req  in  fta_cmd_request128_t  icache fill request; valid in any cycle with cyc&stb=1.
- m0_resp  out  fta_cmd_response128_t  response to master 0.
- m1_req  in  fta_cmd_request128_t  core data request; valid in any cycle with cyc&stb=1.
- m1_resp  out  fta_cmd_response128_t  response to master 1.
- s_req  out  fta_cmd_request128_t  request to the system bus.
- s_resp  in  fta_cmd_response128_t  system bus response.
- busy_o  out  1  high when state is not IDLE.
- ovf_o  out  1  one-cycle pulse when a request is dropped because its slot is full.
- tmo_o  out  1  one-cycle pulse when a timeout fires.

## Operation
- Each master has one pending slot: valid bit plus the full request struct.
- A cycle with mX_req.cyc&stb=1 loads the slot if it is empty, or if it is being freed that same cycle. Otherwise the request is dropped and ovf_o pulses. The request is not modified; tid passes through unchanged.
- State machine states are IDLE, WAIT and BACKOFF. Registers: owner (1 bit), last_grant (1 bit), tmo_cnt (clog2(TIMEOUT) bits), rty_cnt (3 bits), bo_cnt.
- IDLE: if no slot is valid, stay in IDLE. If one slot is valid, grant it. If both are valid, grant the master that is not last_grant.
  - On grant: owner and last_grant are set to the granted master, s_req is loaded with that slot's request (cyc=stb=1), tmo_cnt and rty_cnt are cleared, and the state goes to WAIT.
- WAIT: s_req.cyc/stb are high only in the first WAIT cycle. All s_req bits are zero afterward.
  - s_resp.ack=1: the s_resp struct is registered onto m[owner]_resp, the owner slot is freed, and the state goes to IDLE.
  - s_resp.rty=1 with rty_cnt<MAX_RETRY: rty_cnt is incremented, bo_cnt is cleared, and the state goes to BACKOFF.
  - s_resp.rty=1 with rty_cnt==MAX_RETRY: s_resp (rty=1) is forwarded to the owner, the slot is freed, and the state goes to IDLE.
  - ack and rty together: ack wins.
  - Neither, with tmo_cnt==TIMEOUT-1: m[owner]_resp gets ack=1, err=1, dat=0 and tid from the slot. tmo_o pulses, the slot is freed, and the state goes to IDLE. Otherwise tmo_cnt is incremented.
- BACKOFF: bo_cnt counts up. When bo_cnt==RETRY_DLY-1, s_req is reloaded from the owner slot (cyc=stb=1), tmo_cnt is cleared, and the state goes to WAIT.
- s_resp arriving in IDLE or BACKOFF is ignored. No master sees it.
- At most one mX_resp is non-zero in any cycle. A non-owner response struct is all zeros.

## Timing
- All outputs are registered.
- Request pulse in cycle N → slot valid in N+1 → s_req.cyc high in N+2 if the arbiter was idle.
- s_resp.ack sampled in cycle K → m[owner]_resp.ack high for exactly one cycle, K+1. State is IDLE in K+1, so a waiting slot can be issued with s_req.cyc high in K+2.
- Minimum request-to-response latency is 3 cycles plus the slave latency.
- Retry adds RETRY_DLY+1 cycles between rty being sampled and the reissue pulse.
- Reset, including mid-transaction: slots are invalid, state=IDLE, last_grant=1 (master 0 wins the first tie), and all counters are 0. s_req, m0_resp and m1_resp are all zero; busy_o, ovf_o and tmo_o are 0. A transaction that was in flight is abandoned without any response.

## Test plan
- Single read: m1_req one-cycle pulse, padr=0x0FFF0, tid.channel=1; slave acks 2 cycles after s_req.stb with dat byte 0xEA → s_req.stb high exactly 1 cycle with padr=0x0FFF0; m1_resp.ack high 1 cycle with dat and tid matching the slave; m0_resp stays zero.
- Simultaneous requests right after reset: m0 and m1 pulse in the same cycle → m0 is issued first, m1 is issued the cycle after m0's response; on a second tie, m1 wins (round-robin).
- Retry: slave answers the first 2 issues with rty, then ack → exactly 3 s_req pulses, each reissue RETRY_DLY+1=5 cycles after the rty; exactly one m-side ack.
- Retry exhaustion: slave always answers rty → 8 s_req pulses total, then a single m1_resp with rty=1; busy_o falls.
- Timeout: slave never responds → tmo_o pulses and m0_resp shows ack=1, err=1 exactly TIMEOUT cycles after the first WAIT cycle.
- Overflow and reset: two m1 pulses while m1's slot is occupied → ovf_o pulses, and only the first is issued. Asserting rst_i during WAIT → next cycle all outputs are zero and busy_o=0; a late s_resp.ack produces no m-side response.

Source files
------------

// File: rtl/rf8088_bus_arb.sv
// rf8088_bus_arb -- two-master arbiter/sequencer for the shared 128-bit fta bus.
//
// Master 0 is the instruction-bundle fill path, master 1 the core data master.
// Each master owns a one-entry pending slot loaded by a one-cycle request pulse.
// Slots are granted round-robin and exactly one transaction at a time is issued
// to the slave. Retries back off and are reissued; a silent slave times out.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   m0_req / m0_resp    fill-path request pulse / registered response
//   m1_req / m1_resp    core data request pulse / registered response
//   s_req / s_resp      system bus request (registered) / response
//   busy_o              arbiter not idle
//   ovf_o               one-cycle pulse: a request was dropped (slot full)
//   tmo_o               one-cycle pulse: a transaction timed out

package fta_bus_pkg;

  typedef struct packed {
    logic [3:0] core;
    logic [2:0] channel;
    logic [7:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [15:0]   sel;
    logic [31:0]   padr;
    logic [127:0]  dat;
    fta_tranid_t   tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic          ack;
    logic          rty;
    logic          err;
    fta_tranid_t   tid;
    logic [31:0]   adr;
    logic [127:0]  dat;
  } fta_cmd_response128_t;

endpackage

module rf8088_bus_arb
  import fta_bus_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int RETRY_DLY = 4,
  parameter int MAX_RETRY = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request128_t  m0_req,
  output fta_cmd_response128_t m0_resp,
  input  fta_cmd_request128_t  m1_req,
  output fta_cmd_response128_t m1_resp,
  output fta_cmd_request128_t  s_req,
  input  fta_cmd_response128_t s_resp,
  output logic                 busy_o,
  output logic                 ovf_o,
  output logic                 tmo_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (RETRY_DLY > 1) ? $clog2(RETRY_DLY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_BACKOFF = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [2:0]           rty_cnt_q, rty_cnt_d;
  logic [BW-1:0]        bo_cnt_q, bo_cnt_d;
  logic [1:0]           slot_v_q, slot_v_d;
  fta_cmd_request128_t  slot0_q, slot0_d, slot1_q, slot1_d;
  fta_cmd_request128_t  s_req_q, s_req_d;
  fta_cmd_response128_t m0_resp_q, m0_resp_d, m1_resp_q, m1_resp_d;
  logic                 ovf_q, ovf_d, tmo_q, tmo_d;

  logic                 grant_s;
  logic [1:0]           free_s;
  logic                 resp_v_s;
  fta_cmd_response128_t resp_s;
  fta_cmd_request128_t  own_slot_s;

  assign own_slot_s = owner_q ? slot1_q : slot0_q;

  // Arbitration / transaction FSM: next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    rty_cnt_d    = rty_cnt_q;
    bo_cnt_d     = bo_cnt_q;
    s_req_d      = '0;
    m0_resp_d    = '0;
    m1_resp_d    = '0;
    tmo_d        = 1'b0;
    grant_s      = 1'b0;
    resp_v_s     = 1'b0;
    resp_s       = '0;
    free_s       = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (slot_v_q != 2'b00) begin
          // A tie goes to whichever master was not granted last.
          grant_s      = (slot_v_q == 2'b11) ? ~last_grant_q : slot_v_q[1];
          owner_d      = grant_s;
          last_grant_d = grant_s;
          s_req_d      = grant_s ? slot1_q : slot0_q;
          s_req_d.cyc  = 1'b1;
          s_req_d.stb  = 1'b1;
          tmo_cnt_d    = '0;
          rty_cnt_d    = 3'd0;
          state_d      = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (s_resp.ack) begin
          resp_v_s = 1'b1;
          resp_s   = s_resp;
          state_d  = ST_IDLE;
        end else if (s_resp.rty) begin
          if (rty_cnt_q < 3'(MAX_RETRY)) begin
            rty_cnt_d = rty_cnt_q + 3'd1;
            bo_cnt_d  = '0;
            state_d   = ST_BACKOFF;
          end else begin
            // Retries exhausted: hand the rty to the master.
            resp_v_s = 1'b1;
            resp_s   = s_resp;
            state_d  = ST_IDLE;
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          resp_v_s   = 1'b1;
          resp_s.ack = 1'b1;
          resp_s.err = 1'b1;
          resp_s.tid = own_slot_s.tid;
          tmo_d      = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt_q == BW'(RETRY_DLY - 1)) begin
          s_req_d     = own_slot_s;
          s_req_d.cyc = 1'b1;
          s_req_d.stb = 1'b1;
          tmo_cnt_d   = '0;
          state_d     = ST_WAIT;
        end else begin
          bo_cnt_d = bo_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Route a completed response to the owner only and release its slot.
    if (resp_v_s) begin
      free_s[owner_q] = 1'b1;
      if (owner_q) begin
        m1_resp_d = resp_s;
      end else begin
        m0_resp_d = resp_s;
      end
    end else begin
      free_s = 2'b00;
    end
  end

  // Pending-slot capture; a slot being freed this cycle may accept a new pulse.
  always_comb begin
    slot_v_d = slot_v_q & ~free_s;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    ovf_d    = 1'b0;
    if (m0_req.cyc && m0_req.stb) begin
      if (!slot_v_q[0] || free_s[0]) begin
        slot_v_d[0] = 1'b1;
        slot0_d     = m0_req;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      slot0_d = slot0_q;
    end
    if (m1_req.cyc && m1_req.stb) begin
      if (!slot_v_q[1] || free_s[1]) begin
        slot_v_d[1] = 1'b1;
        slot1_d     = m1_req;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      slot1_d = slot1_q;
    end
  end

  // State, counters, slots and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tmo_cnt_q    <= '0;
      rty_cnt_q    <= 3'd0;
      bo_cnt_q     <= '0;
      slot_v_q     <= 2'b00;
      slot0_q      <= '0;
      slot1_q      <= '0;
      s_req_q      <= '0;
      m0_resp_q    <= '0;
      m1_resp_q    <= '0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rty_cnt_q    <= rty_cnt_d;
      bo_cnt_q     <= bo_cnt_d;
      slot_v_q     <= slot_v_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      s_req_q      <= s_req_d;
      m0_resp_q    <= m0_resp_d;
      m1_resp_q    <= m1_resp_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
    end
  end

  assign s_req   = s_req_q;
  assign m0_resp = m0_resp_q;
  assign m1_resp = m1_resp_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign ovf_o   = ovf_q;
  assign tmo_o   = tmo_q;

endmodule

// File: tb/tb_rf8088_bus_arb.sv
// Directed bench for rf8088_bus_arb: a scripted slave answers each s_req
// strobe after a fixed latency; a per-cycle monitor records strobes and
// responses, which are then compared against hand-computed cycle numbers.
module tb_rf8088_bus_arb;
  import fta_bus_pkg::*;

  logic                 clk;
  logic                 rst_i;
  fta_cmd_request128_t  m0_req, m1_req, s_req;
  fta_cmd_response128_t m0_resp, m1_resp, s_resp;
  logic                 busy_o, ovf_o, tmo_o;

  rf8088_bus_arb dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .m0_req (m0_req),
    .m0_resp(m0_resp),
    .m1_req (m1_req),
    .m1_resp(m1_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .busy_o (busy_o),
    .ovf_o  (ovf_o),
    .tmo_o  (tmo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int fails = 0;

  // monitor state
  int cyc_n = 0;
  int n_stb, n_m0_resp, n_m1_resp, n_ovf, n_tmo;
  int stb_cyc[16];
  logic [31:0] stb_padr[16];
  int m0_first, m1_first, ovf_cyc, tmo_cyc;
  fta_cmd_response128_t last_m0, last_m1;
  logic prev_stb = 1'b0;
  bit stb_multi = 1'b0;
  bit both_resp = 1'b0;

  // scripted slave
  int slv_mode, slv_lat, rty_left, tgt;
  bit rty_always, pend;
  fta_tranid_t ptid;
  logic [127:0] slv_dat;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fta_cmd_request128_t mk_req(input logic [31:0] padr,
                                                  input logic [2:0] ch,
                                                  input logic [7:0] tr);
    fta_cmd_request128_t r;
    r = '0;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    r.sel = 16'hFFFF;
    r.padr = padr;
    r.tid.core = 4'd1;
    r.tid.channel = ch;
    r.tid.tranid = tr;
    return r;
  endfunction

  task automatic clr_mon();
    n_stb = 0; n_m0_resp = 0; n_m1_resp = 0; n_ovf = 0; n_tmo = 0;
    m0_first = -1; m1_first = -1; ovf_cyc = -1; tmo_cyc = -1;
    last_m0 = '0; last_m1 = '0;
    slv_mode = 1; slv_lat = 2; rty_left = 0; rty_always = 1'b0; pend = 1'b0;
    tgt = 0; ptid = '0; slv_dat = 128'hEA;
  endtask

  // One cycle: observe outputs at the falling edge, then drive the slave.
  task automatic step();
    @(negedge clk);
    cyc_n++;
    if (s_req.stb) begin
      if (n_stb < 16) begin
        stb_cyc[n_stb] = cyc_n;
        stb_padr[n_stb] = s_req.padr;
      end
      n_stb++;
      if (prev_stb) stb_multi = 1'b1;
      if (slv_mode != 0) begin
        pend = 1'b1;
        tgt = cyc_n + slv_lat;
        ptid = s_req.tid;
      end
    end
    prev_stb = s_req.stb;
    if (m0_resp != '0) begin
      n_m0_resp++; last_m0 = m0_resp;
      if (m0_first < 0) m0_first = cyc_n;
    end
    if (m1_resp != '0) begin
      n_m1_resp++; last_m1 = m1_resp;
      if (m1_first < 0) m1_first = cyc_n;
    end
    if (m0_resp != '0 && m1_resp != '0) both_resp = 1'b1;
    if (ovf_o) begin n_ovf++; ovf_cyc = cyc_n; end
    if (tmo_o) begin n_tmo++; tmo_cyc = cyc_n; end
    s_resp = '0;
    if (pend && cyc_n == tgt) begin
      pend = 1'b0;
      s_resp.tid = ptid;
      if (rty_left > 0 || rty_always) begin
        s_resp.rty = 1'b1;
        if (rty_left > 0) rty_left--;
      end else begin
        s_resp.ack = 1'b1;
        s_resp.dat = slv_dat;
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m0_req = '0; m1_req = '0; s_resp = '0;
    clr_mon();
    repeat (3) step();
    rst_i = 1'b0;
    clr_mon();
  endtask

  int p;
  fta_cmd_request128_t ra, rb, rc;

  initial begin
    rst_i = 1'b1;
    m0_req = '0; m1_req = '0; s_resp = '0;
    clr_mon();

    // ---- reset state
    repeat (3) step();
    chk("rst_s_req", 256'(s_req), 256'(0));
    chk("rst_m0_resp", 256'(m0_resp), 256'(0));
    chk("rst_m1_resp", 256'(m1_resp), 256'(0));
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_ovf", 256'(ovf_o), 256'(0));
    chk("rst_tmo", 256'(tmo_o), 256'(0));
    rst_i = 1'b0;
    clr_mon();

    // ---- single read from master 1
    step(); p = cyc_n;
    ra = mk_req(32'h0FFF0, 3'd1, 8'h11);
    m1_req = ra; step(); m1_req = '0;
    repeat (10) step();
    chk("rd_nstb", 256'(n_stb), 256'(1));
    chk("rd_stb_cyc", 256'(stb_cyc[0]), 256'(p + 2));
    chk("rd_padr", 256'(stb_padr[0]), 256'(32'h0FFF0));
    chk("rd_nresp", 256'(n_m1_resp), 256'(1));
    chk("rd_resp_cyc", 256'(m1_first), 256'(p + 5));
    chk("rd_ack", 256'(last_m1.ack), 256'(1));
    chk("rd_dat", 256'(last_m1.dat), 256'(128'hEA));
    chk("rd_tid", 256'(last_m1.tid), 256'(ra.tid));
    chk("rd_m0_quiet", 256'(n_m0_resp), 256'(0));

    // ---- simultaneous requests after reset, then a second tie
    do_reset();
    step(); p = cyc_n;
    ra = mk_req(32'h100, 3'd0, 8'h01);
    rb = mk_req(32'h200, 3'd1, 8'h02);
    rc = mk_req(32'h300, 3'd0, 8'h03);
    m0_req = ra; m1_req = rb; step(); m0_req = '0; m1_req = '0;
    repeat (3) step();              // now in cycle p+4, ack for m0 driven
    m0_req = rc; step(); m0_req = '0;
    repeat (15) step();
    chk("tie_nstb", 256'(n_stb), 256'(3));
    chk("tie_first_m0", 256'(stb_padr[0]), 256'(32'h100));
    chk("tie_m0_resp_cyc", 256'(m0_first), 256'(p + 5));
    chk("tie_second_m1", 256'(stb_padr[1]), 256'(32'h200));
    chk("tie_m1_after_m0", 256'(stb_cyc[1]), 256'(p + 6));
    chk("tie2_m1_won_then_m0", 256'(stb_padr[2]), 256'(32'h300));
    chk("tie_reload_no_ovf", 256'(n_ovf), 256'(0));

    // ---- two retries, then ack
    do_reset();
    rty_left = 2;
    step(); p = cyc_n;
    m1_req = mk_req(32'h400, 3'd2, 8'h04); step(); m1_req = '0;
    repeat (30) step();
    chk("rty_nstb", 256'(n_stb), 256'(3));
    chk("rty_reissue1", 256'(stb_cyc[1]), 256'(p + 9));
    chk("rty_reissue2", 256'(stb_cyc[2]), 256'(p + 16));
    chk("rty_nresp", 256'(n_m1_resp), 256'(1));
    chk("rty_resp_ack", 256'({last_m1.ack, last_m1.rty}), 256'(2'b10));

    // ---- retry exhaustion
    do_reset();
    rty_always = 1'b1;
    step(); p = cyc_n;
    m1_req = mk_req(32'h500, 3'd2, 8'h05); step(); m1_req = '0;
    repeat (70) step();
    chk("exh_nstb", 256'(n_stb), 256'(8));
    chk("exh_last_stb", 256'(stb_cyc[7]), 256'(p + 51));
    chk("exh_nresp", 256'(n_m1_resp), 256'(1));
    chk("exh_resp_cyc", 256'(m1_first), 256'(p + 54));
    chk("exh_resp_rty", 256'({last_m1.ack, last_m1.rty}), 256'(2'b01));
    chk("exh_busy_low", 256'(busy_o), 256'(0));

    // ---- timeout on master 0
    do_reset();
    slv_mode = 0;
    step(); p = cyc_n;
    ra = mk_req(32'h600, 3'd0, 8'h06);
    m0_req = ra; step(); m0_req = '0;
    repeat (1040) step();
    chk("tmo_count", 256'(n_tmo), 256'(1));
    chk("tmo_cyc", 256'(tmo_cyc), 256'(p + 1026));
    chk("tmo_resp_cyc", 256'(m0_first), 256'(p + 1026));
    chk("tmo_ack_err", 256'({last_m0.ack, last_m0.rty, last_m0.err}), 256'(3'b101));
    chk("tmo_dat", 256'(last_m0.dat), 256'(0));
    chk("tmo_tid", 256'(last_m0.tid), 256'(ra.tid));
    chk("tmo_m1_quiet", 256'(n_m1_resp), 256'(0));

    // ---- overflow on master 1
    do_reset();
    step(); p = cyc_n;
    ra = mk_req(32'h700, 3'd1, 8'h07);
    rb = mk_req(32'h780, 3'd1, 8'h08);
    m1_req = ra; step(); m1_req = rb; step(); m1_req = '0;
    repeat (10) step();
    chk("ovf_count", 256'(n_ovf), 256'(1));
    chk("ovf_cyc", 256'(ovf_cyc), 256'(p + 2));
    chk("ovf_nstb", 256'(n_stb), 256'(1));
    chk("ovf_first_issued", 256'(stb_padr[0]), 256'(32'h700));
    chk("ovf_nresp", 256'(n_m1_resp), 256'(1));

    // ---- reset during WAIT, late ack ignored
    do_reset();
    slv_mode = 0;
    step(); p = cyc_n;
    ra = mk_req(32'h800, 3'd1, 8'h09);
    m1_req = ra; step(); m1_req = '0;
    step(); step();                 // cycle p+3, in WAIT
    chk("mid_busy", 256'(busy_o), 256'(1));
    rst_i = 1'b1;
    step();
    chk("mid_rst_s_req", 256'(s_req), 256'(0));
    chk("mid_rst_resp", 256'({m0_resp, m1_resp}), 256'(0));
    chk("mid_rst_flags", 256'({busy_o, ovf_o, tmo_o}), 256'(0));
    rst_i = 1'b0;
    step();
    s_resp.ack = 1'b1; s_resp.tid = ra.tid; s_resp.dat = 128'h55;
    step();
    repeat (10) step();
    chk("late_ack_ignored", 256'(n_m0_resp + n_m1_resp), 256'(0));
    chk("no_reissue", 256'(n_stb), 256'(1));

    // ---- whole-run invariants
    chk("one_resp_per_cycle", 256'(both_resp), 256'(0));
    chk("stb_single_cycle", 256'(stb_multi), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
